// File: rtl/us_sched_pkg.sv
// us_sched_pkg
//   Shared definitions for the upstream transmit scheduler slice:
//   FSM state encoding, slot-index width and gap-counter width.
//   Optional feature macro used by the slice: US_SCHED_TIMEOUT_EN.
package us_sched_pkg;

   localparam int unsigned CACHE_NUM_W = 8;
   localparam int unsigned GAP_W       = 16;
   // Mask is widened to the full index range so an 8-bit index never
   // selects outside the vector.
   localparam int unsigned MASK_EXT_W  = 2 ** CACHE_NUM_W;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SCAN = 3'd1,
      S_TRIG = 3'd2,
      S_WAIT = 3'd3,
      S_GAP  = 3'd4,
      S_DONE = 3'd5
   } state_e;

endpackage

// File: rtl/us_sched_slot_timer.sv
// us_sched_slot_timer
//   Loadable down-counter shared by the GAP length count and the WAIT
//   watchdog. Load has priority over tick; the count stops at zero.
//   Ports:
//     clk_i       clock
//     rst_i       synchronous active-high reset (count -> 0)
//     load_i      load load_val_i into the counter
//     load_val_i  value to load
//     tick_i      decrement by one (when non-zero)
//     expired_o   count is zero
module us_sched_slot_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         tick_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/us_transmit_scheduler.sv
// us_transmit_scheduler
//   Walks one us_timming_req_driver through every enabled cache slot once
//   per round: one-cycle start trigger with the slot index, wait for the
//   driver's done pulse, insert a programmable gap, advance.
//   Optional macro US_SCHED_TIMEOUT_EN adds a WAIT watchdog of
//   TIMEOUT_CYCLES cycles and a saturating timeout counter; without it
//   WAIT holds for the done pulse and timeout_cnt_o is tied to zero.
//   Ports:
//     sys_clk_i                 clock
//     rst_i                     synchronous active-high reset
//     enable_i                  scheduler enable (checked in IDLE/SCAN)
//     round_start_i             one-cycle round start pulse
//     cache_en_mask_i           per-slot transmit enable
//     gap_cycles_i              idle cycles between slots
//     transmit_done_pluse_i     done pulse from the driver
//     transmit_start_trigger_o  one-cycle start pulse to the driver
//     cache_num_o               slot index, held until the next trigger
//     round_busy_o              high while not IDLE
//     round_done_pluse_o        one-cycle end-of-round pulse
//     round_overrun_o           round_start_i seen while busy
//     timeout_cnt_o             saturating slot-timeout count
module us_transmit_scheduler
   import us_sched_pkg::*;
#(
   parameter int unsigned TOTAL_NUM      = 104,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                   sys_clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic                   round_start_i,
   input  logic [TOTAL_NUM-1:0]   cache_en_mask_i,
   input  logic [GAP_W-1:0]       gap_cycles_i,
   input  logic                   transmit_done_pluse_i,
   output logic                   transmit_start_trigger_o,
   output logic [CACHE_NUM_W-1:0] cache_num_o,
   output logic                   round_busy_o,
   output logic                   round_done_pluse_o,
   output logic                   round_overrun_o,
   output logic [15:0]            timeout_cnt_o
);

   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TMR_W = (WD_W > GAP_W) ? WD_W : GAP_W;
   localparam logic [CACHE_NUM_W-1:0] LAST_IDX = CACHE_NUM_W'(TOTAL_NUM - 1);

   state_e                 state_q, state_d;
   logic [CACHE_NUM_W-1:0] idx_q, idx_d;
   logic [CACHE_NUM_W-1:0] cache_num_q, cache_num_d;
   logic                   done_q;
   logic                   overrun_q;

   logic                   tmr_load;
   logic [TMR_W-1:0]       tmr_load_val;
   logic                   tmr_tick;
   logic                   tmr_expired;

   logic [MASK_EXT_W-1:0]  mask_ext;
   assign mask_ext = MASK_EXT_W'(cache_en_mask_i);

`ifdef US_SCHED_TIMEOUT_EN
   logic        timeout_hit;
   logic [15:0] timeout_cnt_q;
`endif

   us_sched_slot_timer #(
      .W (TMR_W)
   ) u_slot_timer (
      .clk_i      (sys_clk_i),
      .rst_i      (rst_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .tick_i     (tmr_tick),
      .expired_o  (tmr_expired)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cache_num_d  = cache_num_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_tick     = 1'b0;
`ifdef US_SCHED_TIMEOUT_EN
      timeout_hit  = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (round_start_i && enable_i) begin
               idx_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (!enable_i) begin
               state_d = S_DONE;
            end else if (mask_ext[idx_q]) begin
               cache_num_d = idx_q;
               state_d     = S_TRIG;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_TRIG: begin
            state_d = S_WAIT;
`ifdef US_SCHED_TIMEOUT_EN
            // Count down TIMEOUT_CYCLES WAIT cycles; expiry marks the last one.
            tmr_load     = 1'b1;
            tmr_load_val = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
         end
         S_WAIT: begin
            // Done wins over a coincident watchdog expiry.
            if (transmit_done_pluse_i) begin
               tmr_load     = 1'b1;
               tmr_load_val = TMR_W'(gap_cycles_i);
               state_d      = S_GAP;
            end
`ifdef US_SCHED_TIMEOUT_EN
            else if (tmr_expired) begin
               tmr_load     = 1'b1;
               tmr_load_val = TMR_W'(gap_cycles_i);
               timeout_hit  = 1'b1;
               state_d      = S_GAP;
            end else begin
               tmr_tick = 1'b1;
            end
`endif
         end
         S_GAP: begin
            // Loaded with gap_cycles_i on entry, so GAP spans gap+1 cycles.
            if (tmr_expired) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_SCAN;
               end
            end else begin
               tmr_tick = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cache_num_q <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cache_num_q <= cache_num_d;
         done_q      <= (state_q == S_DONE);
         overrun_q   <= round_start_i && (state_q != S_IDLE);
      end
   end

`ifdef US_SCHED_TIMEOUT_EN
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         timeout_cnt_q <= '0;
      end else if (timeout_hit && (timeout_cnt_q != '1)) begin
         timeout_cnt_q <= timeout_cnt_q + 1'b1;
      end
   end
   assign timeout_cnt_o = timeout_cnt_q;
`else
   assign timeout_cnt_o = '0;
`endif

   assign transmit_start_trigger_o = (state_q == S_TRIG);
   assign cache_num_o              = cache_num_q;
   assign round_busy_o             = (state_q != S_IDLE);
   assign round_done_pluse_o       = done_q;
   assign round_overrun_o          = overrun_q;

endmodule

// File: tb/tb_us_transmit_scheduler.sv
module tb_us_transmit_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        round_start;
   logic [7:0]  mask;
   logic [15:0] gap;
   logic        done_i;
   logic        trig;
   logic [7:0]  cache_num;
   logic        busy;
   logic        rdone;
   logic        overrun;
   logic [15:0] tcnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int trig_num[$];
   int trig_cyc[$];
   int done_cnt = 0;
   int done_cyc = 0;
   int ovr_cnt  = 0;

   int resp_en    = 0;
   int resp_delay = 3;
   int resp_cd    = 0;

   int t0;
   int tb0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   us_transmit_scheduler #(
      .TOTAL_NUM      (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .sys_clk_i                (clk),
      .rst_i                    (rst),
      .enable_i                 (enable),
      .round_start_i            (round_start),
      .cache_en_mask_i          (mask),
      .gap_cycles_i             (gap),
      .transmit_done_pluse_i    (done_i),
      .transmit_start_trigger_o (trig),
      .cache_num_o              (cache_num),
      .round_busy_o             (busy),
      .round_done_pluse_o       (rdone),
      .round_overrun_o          (overrun),
      .timeout_cnt_o            (tcnt)
   );

   // Event recorder, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (trig === 1'b1) begin
            trig_num.push_back(int'(cache_num));
            trig_cyc.push_back(cyc);
         end
         if (rdone === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (overrun === 1'b1) ovr_cnt++;
      end
   end

   // Driver model: done pulse resp_delay cycles after each trigger.
   initial begin
      done_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         done_i = 1'b0;
         if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) done_i = 1'b1;
         end
         if (resp_en != 0 && trig === 1'b1) resp_cd = resp_delay;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      trig_num.delete();
      trig_cyc.delete();
      done_cnt = 0;
      done_cyc = 0;
      ovr_cnt  = 0;
   endtask

   task automatic start_round();
      round_start = 1'b1;
      t0 = cyc;
      step(1);
      round_start = 1'b0;
   endtask

   task automatic wait_round(input string tag, input int limit);
      int n = 0;
      while (done_cnt == 0 && n < limit) begin
         step(1);
         n++;
      end
      step(2);
      chk({tag, "_round_done_seen"}, done_cnt, 1);
   endtask

   task automatic chk_trigs(input string tag, input int exp_num[$]);
      chk({tag, "_trig_count"}, trig_num.size(), exp_num.size());
      for (int i = 0; i < exp_num.size() && i < trig_num.size(); i++) begin
         chk($sformatf("%s_trig%0d_num", tag, i), trig_num[i], exp_num[i]);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; round_start = 1'b0;
      mask = '0; gap = '0;
      step(2);
      chk("rst_trig", int'(trig), 0);
      chk("rst_cache_num", int'(cache_num), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(rdone), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_tcnt", int'(tcnt), 0);
      rst = 1'b0;
      step(1);

      // Start while disabled is ignored.
      start_round();
      chk("disabled_busy", int'(busy), 0);
      chk("disabled_overrun", int'(overrun), 0);
      step(2);

      // Main round: mask A5, gap 2, done 3 cycles after trigger.
      enable = 1'b1; mask = 8'hA5; gap = 16'd2; resp_en = 1; resp_delay = 3;
      clear_mon();
      start_round();
      chk("t1_busy_cycle1", int'(busy), 1);
      wait_round("t1", 200);
      chk_trigs("t1", '{0, 2, 5, 7});
      if (trig_cyc.size() == 4) begin
         chk("t1_first_trig_latency", trig_cyc[0] - t0, 2);
         chk("t1_spacing_0_2", trig_cyc[1] - trig_cyc[0], 9);
         chk("t1_spacing_2_5", trig_cyc[2] - trig_cyc[1], 10);
         chk("t1_spacing_5_7", trig_cyc[3] - trig_cyc[2], 9);
      end
      chk("t1_done_cycle", done_cyc - t0, 38);
      chk("t1_busy_after", int'(busy), 0);
      chk("t1_cache_num_held", int'(cache_num), 7);
      chk("t1_overruns", ovr_cnt, 0);

      // All-zero mask; start re-pulsed in the DONE cycle.
      mask = 8'h00;
      clear_mon();
      start_round();
      step(8);
      round_start = 1'b1;
      step(1);
      round_start = 1'b0;
      chk("t2_done_at_n_plus_2", int'(rdone), 1);
      chk("t2_done_cycle", cyc - t0, 10);
      chk("t2_overrun_in_done", int'(overrun), 1);
      step(1);
      chk("t2_not_restarted", int'(busy), 0);
      chk("t2_trig_count", trig_num.size(), 0);

      // Start re-pulsed during WAIT.
      mask = 8'h12;
      clear_mon();
      start_round();
      step(4);
      round_start = 1'b1;
      step(1);
      round_start = 1'b0;
      chk("t3_overrun_pulse", int'(overrun), 1);
      wait_round("t3", 200);
      chk_trigs("t3", '{1, 4});
      chk("t3_overrun_count", ovr_cnt, 1);

      // enable dropped during WAIT of slot 2.
      mask = 8'hFF;
      clear_mon();
      start_round();
      begin
         int n = 0;
         while (trig_num.size() < 3 && n < 100) begin
            step(1);
            n++;
         end
      end
      chk("t4_reached_slot2", trig_num.size(), 3);
      tb0 = (trig_cyc.size() > 2) ? trig_cyc[2] : 0;
      enable = 1'b0;
      wait_round("t4", 100);
      chk_trigs("t4", '{0, 1, 2});
      chk("t4_done_after_slot2", done_cyc - tb0, 9);
      enable = 1'b1;

      // Reset during GAP, then fresh round from slot 0.
      mask = 8'h06; gap = 16'd5;
      clear_mon();
      start_round();
      begin
         int n = 0;
         while (trig_num.size() < 1 && n < 100) begin
            step(1);
            n++;
         end
      end
      step(4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("t5_rst_trig", int'(trig), 0);
      chk("t5_rst_cache_num", int'(cache_num), 0);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_rst_done", int'(rdone), 0);
      chk("t5_rst_overrun", int'(overrun), 0);
      step(4);
      gap = 16'd2;
      clear_mon();
      start_round();
      wait_round("t5", 200);
      chk_trigs("t5", '{1, 2});
      if (trig_cyc.size() > 0) chk("t5_restart_latency", trig_cyc[0] - t0, 3);

`ifdef US_SCHED_TIMEOUT_EN
      // Watchdog: no done pulses.
      resp_en = 0; mask = 8'h03; gap = 16'd1;
      clear_mon();
      start_round();
      wait_round("t6", 300);
      chk_trigs("t6", '{0, 1});
      chk("t6_timeout_cnt", int'(tcnt), 2);
`else
      chk("tcnt_tied_zero", int'(tcnt), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
